// File: rtl/router_fifo.sv
// Single-clock FIFO responder for the router fifo_if protocol: occupancy,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module router_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rd,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  full,
  output logic                  mty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THR = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_THR = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  rd_ok;
  logic                  wr_ok;

  // Status comes from registered pointers only; the extra MSB separates full from empty.
  always_comb begin
    level        = wptr - rptr;
    mty          = (wptr == rptr);
    full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    almost_full  = (level >= AF_THR);
    almost_empty = (level <= AE_THR);
    rd_ok        = rd & ~mty;
    wr_ok        = wr & (~full | rd_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      q    <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        q    <= mem[rptr[ADDR_WIDTH-1:0]];
        rptr <= rptr + 1'b1;
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr & full & ~rd_ok) ovf <= 1'b1;
      else if (clr_err)       ovf <= 1'b0;
      if (rd & mty)           udf <= 1'b1;
      else if (clr_err)       udf <= 1'b0;
    end
  end

endmodule
